// File: rtl/jstk_poll_scheduler.sv
// Poll scheduler: shares one 40-bit SPI master between two joysticks,
// builds LED command words and registers decoded x/y/btn per player.
module jstk_poll_scheduler #(
   parameter int unsigned PERIOD_CYC  = 500000,
   parameter int unsigned GAP_CYC     = 1000,
   parameter int unsigned TIMEOUT_CYC = 8192
) (
   input  logic        clk50M,
   input  logic        rst,
   input  logic        poll_en,
   input  logic [1:0]  led0,
   input  logic [1:0]  led1,
   output logic        spi_start,
   output logic [39:0] spi_tx,
   input  logic [39:0] spi_rx,
   input  logic        spi_done,
   input  logic        spi_cs,
   output logic [1:0]  cs_n,
   output logic [9:0]  x0,
   output logic [9:0]  y0,
   output logic [1:0]  btn0,
   output logic [9:0]  x1,
   output logic [9:0]  y1,
   output logic [1:0]  btn1,
   output logic [1:0]  upd,
   output logic [1:0]  stale
);

   localparam int PW = (PERIOD_CYC  > 1) ? $clog2(PERIOD_CYC)  : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int GW = (GAP_CYC     > 1) ? $clog2(GAP_CYC)     : 1;

   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_GAP
   } state_t;

   state_t state_q, state_d;
   logic   sel_q, sel_d;

   logic [PW-1:0] per_q, per_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [39:0]   tx_q, tx_d;

   logic [1:0][9:0] x_q, x_d;
   logic [1:0][9:0] y_q, y_d;
   logic [1:0][1:0] btn_q, btn_d;
   logic [1:0]      upd_q, upd_d;
   logic [1:0]      stale_q, stale_d;

   logic per_wrap;
   logic round_req;
   logic tmo_hit;
   logic gap_end;

   assign per_wrap  = (per_q == PER_LAST);
   assign round_req = per_wrap & poll_en;
   assign tmo_hit   = (tmr_q == TMO_LAST);
   assign gap_end   = (gap_q == GAP_LAST);

   always_ff @(posedge clk50M) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= 1'b0;
         per_q   <= '0;
         tmr_q   <= '0;
         gap_q   <= '0;
         tx_q    <= '0;
         x_q     <= {2{10'd512}};
         y_q     <= {2{10'd512}};
         btn_q   <= '0;
         upd_q   <= '0;
         stale_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         per_q   <= per_d;
         tmr_q   <= tmr_d;
         gap_q   <= gap_d;
         tx_q    <= tx_d;
         x_q     <= x_d;
         y_q     <= y_d;
         btn_q   <= btn_d;
         upd_q   <= upd_d;
         stale_q <= stale_d;
      end
   end

   // sel only moves on GAP->START so cs_n never switches mid-transfer
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         S_IDLE: begin
            if (round_req) begin
               state_d = S_START;
               sel_d   = 1'b0;
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (spi_done || tmo_hit) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_end) begin
               if (!sel_q) begin
                  sel_d   = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      per_d   = per_wrap ? '0 : per_q + PW'(1);
      tmr_d   = (state_q == S_WAIT) ? tmr_q + TW'(1) : '0;
      gap_d   = (state_q == S_GAP) ? gap_q + GW'(1) : '0;
      tx_d    = tx_q;
      x_d     = x_q;
      y_d     = y_q;
      btn_d   = btn_q;
      upd_d   = '0;
      stale_d = stale_q;

      if (state_d == S_START && state_q != S_START) begin
         tx_d = {6'b100000, (sel_d ? led1 : led0), 32'h0};
      end

      // first received byte sits in spi_rx[39:32]
      if (state_q == S_WAIT) begin
         if (spi_done) begin
            x_d[sel_q]     = {spi_rx[25:24], spi_rx[39:32]};
            y_d[sel_q]     = {spi_rx[9:8], spi_rx[23:16]};
            btn_d[sel_q]   = spi_rx[1:0];
            upd_d[sel_q]   = 1'b1;
            stale_d[sel_q] = 1'b0;
         end else if (tmo_hit) begin
            stale_d[sel_q] = 1'b1;
         end
      end
   end

   // chip-selects stay parked high while idle, even if the core is still busy
   always_comb begin
      spi_start = (state_q == S_START);
      cs_n      = 2'b11;
      if (state_q != S_IDLE) begin
         cs_n[sel_q] = spi_cs;
      end
   end

   assign spi_tx = tx_q;
   assign x0     = x_q[0];
   assign y0     = y_q[0];
   assign btn0   = btn_q[0];
   assign x1     = x_q[1];
   assign y1     = y_q[1];
   assign btn1   = btn_q[1];
   assign upd    = upd_q;
   assign stale  = stale_q;

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Directed bench for jstk_poll_scheduler with a simple SPI core model
// that replies a fixed number of cycles after each spi_start.
module tb_jstk_poll_scheduler;

   localparam int PER   = 200;
   localparam int GAP   = 4;
   localparam int TMO   = 64;
   localparam int REPLY = 50;

   logic        clk50M = 1'b0;
   logic        rst = 1'b1;
   logic        poll_en = 1'b0;
   logic [1:0]  led0 = 2'b01;
   logic [1:0]  led1 = 2'b10;
   logic        spi_start;
   logic [39:0] spi_tx;
   logic [39:0] spi_rx = '0;
   logic        spi_done = 1'b0;
   logic        spi_cs = 1'b1;
   logic [1:0]  cs_n;
   logic [9:0]  x0, y0, x1, y1;
   logic [1:0]  btn0, btn1, upd, stale;

   jstk_poll_scheduler #(
      .PERIOD_CYC (PER),
      .GAP_CYC    (GAP),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk50M   (clk50M),
      .rst      (rst),
      .poll_en  (poll_en),
      .led0     (led0),
      .led1     (led1),
      .spi_start(spi_start),
      .spi_tx   (spi_tx),
      .spi_rx   (spi_rx),
      .spi_done (spi_done),
      .spi_cs   (spi_cs),
      .cs_n     (cs_n),
      .x0       (x0),
      .y0       (y0),
      .btn0     (btn0),
      .x1       (x1),
      .y1       (y1),
      .btn1     (btn1),
      .upd      (upd),
      .stale    (stale)
   );

   always #10 clk50M = ~clk50M;

   int cyc = 0;
   always @(posedge clk50M) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // event log
   int          st_n = 0;
   int          up_n = 0;
   int          st_cyc[16];
   logic [39:0] st_tx[16];
   int          up_cyc[16];
   logic [1:0]  up_val[16];

   initial forever begin
      @(posedge clk50M);
      #1;
      if (spi_start && st_n < 16) begin
         st_cyc[st_n] = cyc;
         st_tx[st_n]  = spi_tx;
         st_n++;
      end
      if (upd != 2'b00 && up_n < 16) begin
         up_cyc[up_n] = cyc;
         up_val[up_n] = upd;
         up_n++;
      end
   end

   // spi core model
   logic [39:0] rx_p[2];
   bit          drop_p[2];
   int          m_n = 0;
   int          m_p = 0;
   logic [1:0]  m_cs[16];
   int          m_done[16];

   initial forever begin
      @(posedge clk50M);
      #1;
      if (spi_start) begin
         spi_cs = 1'b0;
         #1;
         if (m_n < 16) m_cs[m_n] = cs_n;
         m_p = (cs_n[0] == 1'b0) ? 0 : 1;
         repeat (REPLY) @(posedge clk50M);
         #1;
         if (!drop_p[m_p]) begin
            spi_rx   = rx_p[m_p];
            spi_done = 1'b1;
         end
         if (m_n < 16) m_done[m_n] = cyc;
         m_n++;
         @(posedge clk50M);
         #1;
         spi_done = 1'b0;
         spi_cs   = 1'b1;
      end
   end

   task automatic wait_upd(input int target, input int budget,
                           input string tag);
      int n = 0;
      while (up_n < target && n < budget) begin
         @(posedge clk50M);
         #1;
         n++;
      end
      chk(tag, 64'(up_n >= target), 64'd1);
   endtask

   task automatic wait_start(input int target, input int budget,
                             input string tag);
      int n = 0;
      while (st_n < target && n < budget) begin
         @(posedge clk50M);
         #1;
         n++;
      end
      chk(tag, 64'(st_n >= target), 64'd1);
   endtask

   int b;
   int bu;

   initial begin
      rx_p[0]   = 40'h12_02_34_01_03;
      rx_p[1]   = 40'hFF_03_A5_01_02;
      drop_p[0] = 1'b0;
      drop_p[1] = 1'b0;

      repeat (3) @(posedge clk50M);
      #1;
      rst = 1'b0;

      chk("rst_x0", 64'(x0), 64'd512);
      chk("rst_y0", 64'(y0), 64'd512);
      chk("rst_x1", 64'(x1), 64'd512);
      chk("rst_y1", 64'(y1), 64'd512);
      chk("rst_btn", 64'({btn1, btn0}), 64'd0);
      chk("rst_cs_n", 64'(cs_n), 64'd3);
      chk("rst_start", 64'(spi_start), 64'd0);
      chk("rst_upd", 64'(upd), 64'd0);
      chk("rst_stale", 64'(stale), 64'd0);

      // no polling while disabled
      b = st_n;
      repeat (3 * PER) @(posedge clk50M);
      #1;
      chk("dis_nostart", 64'(st_n - b), 64'd0);

      // normal round
      b  = st_n;
      bu = up_n;
      poll_en = 1'b1;
      wait_upd(bu + 2, 3 * PER, "norm_wait");
      poll_en = 1'b0;
      chk("norm_starts", 64'(st_n - b), 64'd2);
      chk("norm_tx0", 64'(st_tx[b]), 64'h81_0000_0000);
      chk("norm_tx1", 64'(st_tx[b+1]), 64'h82_0000_0000);
      chk("norm_cs0", 64'(m_cs[b]), 64'd2);
      chk("norm_cs1", 64'(m_cs[b+1]), 64'd1);
      chk("norm_upd0", 64'(up_val[bu]), 64'd1);
      chk("norm_upd1", 64'(up_val[bu+1]), 64'd2);
      chk("norm_lat", 64'(up_cyc[bu] - m_done[b]), 64'd1);
      chk("norm_gap", 64'(st_cyc[b+1] - up_cyc[bu]), 64'(GAP));
      chk("dec_x1", 64'(x1), 64'd1023);
      chk("dec_y1", 64'(y1), 64'd421);
      chk("dec_btn1", 64'(btn1), 64'd2);
      chk("dec_x0", 64'(x0), 64'd530);
      chk("dec_y0", 64'(y0), 64'd308);
      chk("dec_btn0", 64'(btn0), 64'd3);
      chk("norm_stale", 64'(stale), 64'd0);

      // player 0 times out, player 1 still polled
      drop_p[0] = 1'b1;
      rx_p[1]   = 40'h40_01_80_02_01;
      b  = st_n;
      bu = up_n;
      poll_en = 1'b1;
      wait_upd(bu + 1, 3 * PER, "tmo_wait");
      poll_en = 1'b0;
      repeat (10) @(posedge clk50M);
      #1;
      chk("tmo_starts", 64'(st_n - b), 64'd2);
      chk("tmo_updn", 64'(up_n - bu), 64'd1);
      chk("tmo_upd", 64'(up_val[bu]), 64'd2);
      chk("tmo_stale", 64'(stale), 64'd1);
      chk("tmo_x0", 64'(x0), 64'd530);
      chk("tmo_spacing", 64'(st_cyc[b+1] - st_cyc[b]), 64'(1 + TMO + GAP));
      chk("tmo_x1", 64'(x1), 64'd320);
      chk("tmo_y1", 64'(y1), 64'd640);
      chk("tmo_btn1", 64'(btn1), 64'd1);

      // good reply clears stale; poll_en drops mid-round
      drop_p[0] = 1'b0;
      b  = st_n;
      bu = up_n;
      poll_en = 1'b1;
      wait_start(b + 1, 2 * PER, "mid_wait_st");
      poll_en = 1'b0;
      wait_upd(bu + 2, 2 * PER, "mid_wait_upd");
      chk("mid_stale", 64'(stale), 64'd0);
      repeat (3 * PER) @(posedge clk50M);
      #1;
      chk("mid_starts", 64'(st_n - b), 64'd2);

      // reset while waiting on the core
      b  = st_n;
      bu = up_n;
      poll_en = 1'b1;
      wait_start(b + 1, 2 * PER, "rstw_wait");
      poll_en = 1'b0;
      repeat (10) @(posedge clk50M);
      #1;
      rst = 1'b1;
      @(posedge clk50M);
      #1;
      rst = 1'b0;
      chk("rstw_cs_n", 64'(cs_n), 64'd3);
      chk("rstw_start", 64'(spi_start), 64'd0);
      chk("rstw_x0", 64'(x0), 64'd512);
      chk("rstw_x1", 64'(x1), 64'd512);
      repeat (100) @(posedge clk50M);
      #1;
      chk("rstw_noupd", 64'(up_n - bu), 64'd0);
      chk("rstw_starts", 64'(st_n - b), 64'd1);
      chk("rstw_cs_end", 64'(cs_n), 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
